mdu_iter: RTL
=============

Name: mdu_iter

Overview:
- Iterative RV32M multiply/divide unit in the execute stage, directly downstream of the register file.
- Consumes the rs1/rs2 operand values read from the register file.
- Executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU and returns a 32-bit result for the EX/MEM pipeline register.
- The pipeline stalls while busy=1 and captures result on done=1.

Parameters:
- XLEN, 32, operand/result width. Only 32 is supported.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- start  in  1  request new operation; sampled only in IDLE
- flush  in  1  pipeline flush; aborts any operation
- op  in  3  funct3 of the M-extension instruction (mdu_op_t)
- a  in  XLEN  rs1 value
- b  in  XLEN  rs2 value
- busy  out  1  high in CALC and DONE states
- done  out  1  one-cycle pulse: result valid
- result  out  XLEN  registered result; held until the next result is written

Behaviour:
- Reset (async, any state): state=IDLE; busy=0; done=0; result=0; all internal registers cleared.
- States and transitions:
  - IDLE: on an edge with start=1 and flush=0, latch op, the magnitudes of a/b and the sign flags.
  - IDLE, normal operation: go to CALC with count=0.
  - IDLE, special case: go straight to DONE and write result on that same edge.
  - CALC: one radix-2 iteration per edge.
    - Multiply: shift-add into a 64-bit product.
    - Divide: restoring shift-subtract producing quotient and remainder.
    - count increments each edge. The edge with count==31 performs the final iteration, applies the sign fix-up, writes result and goes to DONE.
  - DONE: done=1 for exactly one cycle; the next edge returns to IDLE unconditionally. start is ignored in DONE.
- Latency, with E0 = the accepting edge:
  - Normal operations: done=1 in the cycle after edge E32; 33 cycles from acceptance.
  - Special cases: done=1 in the cycle after E0.
  - The next start is accepted no earlier than the edge that leaves DONE plus one, i.e. an IDLE cycle is required.
- Signedness:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: a signed, b unsigned.
  - MULHU, DIVU, REMU: both operands unsigned.
  - Magnitudes are computed on accept. The final negation uses two's complement over 64 bits (multiply) or 32 bits (divide).
- Result selection:
  - MUL: product[31:0].
  - MULH/MULHSU/MULHU: product[63:32].
  - DIV/DIVU: quotient.
  - REM/REMU: remainder; its sign follows the dividend.
- Special cases (no CALC):
  - Divide by zero: DIV/DIVU result=0xFFFFFFFF; REM/REMU result=a.
  - Signed overflow DIV with a=0x80000000, b=0xFFFFFFFF: result=0x80000000. REM with the same operands: result=0.
- flush:
  - In any state, flush forces state=IDLE on the next edge, suppresses done and leaves result unchanged.
  - flush and start in the same IDLE cycle: flush wins, nothing is accepted.
  - flush in the DONE cycle: done is still seen that cycle. The consumer must ignore it because it is flushing too.
- Operand inputs may change freely after the accepting edge; the unit uses only latched copies.
- Reset asserted mid-operation: everything clears immediately, with no done.

Decomposition:
- Shared package rv32m_pkg holds:
  - mdu_op_t enum: MUL=3'b000, MULH=001, MULHSU=010, MULHU=011, DIV=100, DIVU=101, REM=110, REMU=111.
  - mdu_state_t enum: IDLE, CALC, DONE.
  - Constants ITER_COUNT=32 and the overflow patterns.
- One sub-module is natural: mdu_div_step, the combinational single restoring-division iteration (remainder/quotient in, remainder/quotient out). The multiply step stays inline.

Test Plan:
- MUL a=7, b=0xFFFFFFFD (-3) -> result=0xFFFFFFEB; done exactly 33 cycles after the accepting edge; busy high throughout.
- MULH a=b=0x80000000 -> 0x40000000; MULHU same operands -> 0x40000000; MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD. REM with the same operands -> 0xFFFFFFFF. DIVU a=100, b=7 -> 14. REMU with the same operands -> 2.
- DIVU a=0x12345678, b=0 -> 0xFFFFFFFF with done the cycle after the accepting edge. REM with the same operands -> 0x12345678. DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000. REM with the same operands -> 0.
- Start DIV, assert flush 10 cycles later -> busy=0 next cycle, no done pulse, result unchanged. A new start on the following cycle completes correctly.
- Start MUL, assert rst asynchronously mid-CALC -> busy/done/result go to 0 immediately. start held high while busy -> ignored; exactly one done per accepted op.

Source files
------------

// File: rtl/rv32m_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// operation and state encodings, iteration count and the signed
// division overflow operand patterns.
package rv32m_pkg;

    typedef enum logic [2:0] {
        MUL    = 3'b000,
        MULH   = 3'b001,
        MULHSU = 3'b010,
        MULHU  = 3'b011,
        DIV    = 3'b100,
        DIVU   = 3'b101,
        REM    = 3'b110,
        REMU   = 3'b111
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mdu_state_t;

    localparam int          ITER_COUNT   = 32;
    localparam logic [4:0]  LAST_ITER    = 5'(ITER_COUNT - 1);
    localparam logic [31:0] OVF_DIVIDEND = 32'h8000_0000;
    localparam logic [31:0] OVF_DIVISOR  = 32'hFFFF_FFFF;

    // Two's complement magnitude of a value when its sign flag is set.
    function automatic logic [31:0] magnitude(input logic [31:0] value, input logic neg);
        return neg ? (~value + 32'd1) : value;
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, subtract the divisor if it fits, and shift the
// resulting quotient bit into the low end of the quotient register.
module mdu_div_step (
    input  logic [31:0] i_rem,
    input  logic [31:0] i_quo,
    input  logic [31:0] i_divisor,
    output logic [31:0] o_rem,
    output logic [31:0] o_quo
);

    logic [32:0] w_shifted;
    logic [32:0] w_diff;
    logic        w_fits;

    // Trial subtraction; bit 32 of the difference is the borrow, so a
    // clear borrow means the divisor fits into the shifted remainder.
    always_comb begin
        w_shifted = {i_rem, i_quo[31]};
        w_diff    = w_shifted - {1'b0, i_divisor};
        w_fits    = ~w_diff[32];
        o_rem     = w_fits ? w_diff[31:0] : w_shifted[31:0];
        o_quo     = {i_quo[30:0], w_fits};
    end

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit. Operands are converted to
// magnitudes on acceptance, 32 radix-2 iterations run in CALC, and the
// sign fix-up plus result selection happens on the final iteration edge.
// Division by zero and signed overflow bypass CALC entirely.
module mdu_iter
    import rv32m_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    mdu_state_t  r_state;
    mdu_state_t  w_nextState;
    mdu_op_t     r_op;
    mdu_op_t     w_op;
    logic [4:0]  r_count;
    logic [31:0] r_opa;
    logic [31:0] r_opb;
    logic        r_negA;
    logic        r_negB;
    logic [63:0] r_prod;
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_result;

    logic        w_accept;
    logic        w_signedA;
    logic        w_signedB;
    logic        w_negA;
    logic        w_negB;
    logic        w_divZero;
    logic        w_overflow;
    logic        w_special;
    logic [31:0] w_specialResult;
    logic        w_lastIter;
    logic [32:0] w_mulSum;
    logic [63:0] w_prodNext;
    logic [63:0] w_prodFinal;
    logic [31:0] w_remNext;
    logic [31:0] w_quoNext;
    logic [31:0] w_remFinal;
    logic [31:0] w_quoFinal;
    logic [31:0] w_calcResult;

    assign w_op   = mdu_op_t'(op);
    assign result = r_result;

    // Operand decode at acceptance: signedness, sign flags and the special
    // cases that produce their result without iterating.
    always_comb begin
        w_accept   = (r_state == IDLE) && start && !flush;
        w_signedA  = !(w_op == MULHU || w_op == DIVU || w_op == REMU);
        w_signedB  = (w_op == MUL || w_op == MULH || w_op == DIV || w_op == REM);
        w_negA     = w_signedA && a[31];
        w_negB     = w_signedB && b[31];
        w_divZero  = w_op[2] && (b == 32'd0);
        w_overflow = (w_op == DIV || w_op == REM) && (a == OVF_DIVIDEND) && (b == OVF_DIVISOR);
        w_special  = w_divZero || w_overflow;
        if (w_divZero) begin
            w_specialResult = w_op[1] ? a : 32'hFFFF_FFFF;
        end else begin
            w_specialResult = w_op[1] ? 32'd0 : OVF_DIVIDEND;
        end
    end

    mdu_div_step u_divStep (
        .i_rem     (r_rem),
        .i_quo     (r_quo),
        .i_divisor (r_opb),
        .o_rem     (w_remNext),
        .o_quo     (w_quoNext)
    );

    // Multiply iteration (add multiplicand into the high half when the
    // multiplier LSB is set, then shift right) and the final sign fix-up
    // and result selection for whichever operation is in flight.
    always_comb begin
        w_lastIter  = (r_count == LAST_ITER);
        w_mulSum    = {1'b0, r_prod[63:32]} + (r_prod[0] ? {1'b0, r_opa} : 33'd0);
        w_prodNext  = {w_mulSum, r_prod[31:1]};
        w_prodFinal = (r_negA ^ r_negB) ? (~w_prodNext + 64'd1) : w_prodNext;
        w_quoFinal  = (r_negA ^ r_negB) ? (~w_quoNext + 32'd1) : w_quoNext;
        w_remFinal  = r_negA ? (~w_remNext + 32'd1) : w_remNext;
        case (r_op)
            MUL:                    w_calcResult = w_prodFinal[31:0];
            MULH, MULHSU, MULHU:    w_calcResult = w_prodFinal[63:32];
            DIV, DIVU:              w_calcResult = w_quoFinal;
            REM, REMU:              w_calcResult = w_remFinal;
            default:                w_calcResult = 32'd0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and status outputs; flush always returns to IDLE.
    always_comb begin
        w_nextState = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_nextState = w_special ? DONE : CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (flush) begin
                    w_nextState = IDLE;
                end else if (w_lastIter) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Datapath: latch operands on acceptance, iterate in CALC, and write
    // the result either immediately (special case) or on the last iteration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op     <= MUL;
            r_count  <= 5'd0;
            r_opa    <= 32'd0;
            r_opb    <= 32'd0;
            r_negA   <= 1'b0;
            r_negB   <= 1'b0;
            r_prod   <= 64'd0;
            r_rem    <= 32'd0;
            r_quo    <= 32'd0;
            r_result <= 32'd0;
        end else if (w_accept) begin
            r_op    <= w_op;
            r_count <= 5'd0;
            r_opa   <= magnitude(a, w_negA);
            r_opb   <= magnitude(b, w_negB);
            r_negA  <= w_negA;
            r_negB  <= w_negB;
            r_prod  <= {32'd0, magnitude(b, w_negB)};
            r_rem   <= 32'd0;
            r_quo   <= magnitude(a, w_negA);
            if (w_special) begin
                r_result <= w_specialResult;
            end
        end else if (r_state == CALC && !flush) begin
            r_count <= r_count + 5'd1;
            r_prod  <= w_prodNext;
            r_rem   <= w_remNext;
            r_quo   <= w_quoNext;
            if (w_lastIter) begin
                r_result <= w_calcResult;
            end
        end
    end

endmodule
